// File: rtl/axi_rd_budget_tracker.sv
// Read-path latency guard: tracks outstanding AXI reads per ID against prescaled tick budgets,
// watches AR-channel stalls, and keeps a sticky first-error record plus a saturating error count.
module axi_rd_budget_tracker #(
    parameter int IdWidth      = 6,
    parameter int NumSlots     = 8,
    parameter int CntWidth     = 10,
    parameter int PrescalerDiv = 16,
    parameter int ErrCntWidth  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [CntWidth-1:0]    cfg_ar_budget_i,
    input  logic [CntWidth-1:0]    cfg_r_base_i,
    input  logic [CntWidth-1:0]    cfg_r_unit_i,
    input  logic                   ar_valid_i,
    input  logic                   ar_ready_i,
    input  logic [IdWidth-1:0]     ar_id_i,
    input  logic [7:0]             ar_len_i,
    input  logic                   r_valid_i,
    input  logic                   r_ready_i,
    input  logic                   r_last_i,
    input  logic [IdWidth-1:0]     r_id_i,
    output logic                   ar_stall_o,
    output logic                   busy_o,
    output logic                   timeout_o,
    output logic [IdWidth-1:0]     err_id_o,
    output logic [1:0]             err_kind_o,
    output logic [ErrCntWidth-1:0] err_cnt_o,
    input  logic                   err_clear_i
);

    localparam int PresW = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
    localparam int SlotW = $clog2(NumSlots);
    localparam int BudW  = CntWidth + 9;

    typedef enum logic [1:0] {
        ERR_AR_TIMEOUT = 2'd0,
        ERR_R_TIMEOUT  = 2'd1,
        ERR_UNEXP_R    = 2'd2,
        ERR_OVERFLOW   = 2'd3
    } err_kind_e;

    logic [PresW-1:0]       presc_q, presc_d;
    logic [CntWidth-1:0]    ar_cnt_q, ar_cnt_d;
    logic [NumSlots-1:0]    act_q, act_d;
    logic [IdWidth-1:0]     slot_id_q  [NumSlots];
    logic [IdWidth-1:0]     slot_id_d  [NumSlots];
    logic [CntWidth-1:0]    slot_cnt_q [NumSlots];
    logic [CntWidth-1:0]    slot_cnt_d [NumSlots];
    logic                   timeout_q, timeout_d;
    logic [IdWidth-1:0]     err_id_q, err_id_d;
    err_kind_e              err_kind_q, err_kind_d;
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

    logic                tick;
    logic                ar_hs, r_hs;
    logic [NumSlots-1:0] ar_hit, r_hit, r_to;
    logic                alloc, ovf_err, unexp_err, ar_to, any_err;
    logic [SlotW-1:0]    free_idx, to_idx;
    logic [BudW-1:0]     budget_wide;
    logic [CntWidth-1:0] budget;
    logic [IdWidth-1:0]  new_id;
    err_kind_e           new_kind;

    assign tick    = (presc_q == PresW'(PrescalerDiv - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    assign ar_hs = ar_valid_i & ar_ready_i;
    assign r_hs  = r_valid_i & r_ready_i;

    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            ar_hit[i] = act_q[i] & (slot_id_q[i] == ar_id_i);
            r_hit[i]  = act_q[i] & (slot_id_q[i] == r_id_i);
        end
    end

    assign ar_stall_o = enable_i & ar_valid_i & ((&act_q) | (|ar_hit));
    assign alloc      = enable_i & ar_hs & ~ar_stall_o;
    assign ovf_err    = enable_i & ar_hs & ar_stall_o;
    assign unexp_err  = enable_i & r_hs & ~(|r_hit);

    always_comb begin
        free_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!act_q[i]) free_idx = SlotW'(i);
        end
    end

    // Wide enough that 256 beats of the largest unit plus base cannot wrap before saturation.
    assign budget_wide = BudW'(cfg_r_base_i)
                       + BudW'({1'b0, ar_len_i} + 9'd1) * BudW'(cfg_r_unit_i);
    assign budget      = (budget_wide > BudW'({CntWidth{1'b1}})) ? '1 : budget_wide[CntWidth-1:0];

    // A final beat arriving on the expiry tick completes the read rather than timing it out.
    always_comb begin
        act_d = act_q;
        r_to  = '0;
        for (int i = 0; i < NumSlots; i++) begin
            slot_id_d[i]  = slot_id_q[i];
            slot_cnt_d[i] = slot_cnt_q[i];
            if (act_q[i]) begin
                if (r_hs && r_last_i && r_hit[i]) begin
                    act_d[i] = 1'b0;
                end else if (tick) begin
                    if (slot_cnt_q[i] == '0) begin
                        r_to[i]  = 1'b1;
                        act_d[i] = 1'b0;
                    end else begin
                        slot_cnt_d[i] = slot_cnt_q[i] - 1'b1;
                    end
                end
            end
        end
        if (alloc) begin
            act_d[free_idx]      = 1'b1;
            slot_id_d[free_idx]  = ar_id_i;
            slot_cnt_d[free_idx] = budget;
        end
        if (!enable_i) begin
            act_d = '0;
            r_to  = '0;
        end
    end

    always_comb begin
        to_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (r_to[i]) to_idx = SlotW'(i);
        end
    end

    always_comb begin
        ar_to    = 1'b0;
        ar_cnt_d = ar_cnt_q;
        if (!enable_i || !ar_valid_i || ar_hs) begin
            ar_cnt_d = cfg_ar_budget_i;
        end else if (tick) begin
            if (ar_cnt_q == '0) begin
                ar_to    = 1'b1;
                ar_cnt_d = cfg_ar_budget_i;
            end else begin
                ar_cnt_d = ar_cnt_q - 1'b1;
            end
        end
    end

    assign any_err = ovf_err | unexp_err | ar_to | (|r_to);

    always_comb begin
        new_kind = ERR_R_TIMEOUT;
        new_id   = slot_id_q[to_idx];
        if (ovf_err) begin
            new_kind = ERR_OVERFLOW;
            new_id   = ar_id_i;
        end else if (unexp_err) begin
            new_kind = ERR_UNEXP_R;
            new_id   = r_id_i;
        end else if (ar_to) begin
            new_kind = ERR_AR_TIMEOUT;
            new_id   = ar_id_i;
        end
    end

    always_comb begin
        timeout_d  = timeout_q;
        err_id_d   = err_id_q;
        err_kind_d = err_kind_q;
        err_cnt_d  = err_cnt_q;
        if (err_clear_i) begin
            timeout_d  = any_err;
            err_id_d   = any_err ? new_id : '0;
            err_kind_d = any_err ? new_kind : ERR_AR_TIMEOUT;
            err_cnt_d  = any_err ? ErrCntWidth'(1) : '0;
        end else if (any_err) begin
            if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
            if (!timeout_q) begin
                timeout_d  = 1'b1;
                err_id_d   = new_id;
                err_kind_d = new_kind;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q    <= '0;
            ar_cnt_q   <= '0;
            act_q      <= '0;
            timeout_q  <= 1'b0;
            err_id_q   <= '0;
            err_kind_q <= ERR_AR_TIMEOUT;
            err_cnt_q  <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                slot_id_q[i]  <= '0;
                slot_cnt_q[i] <= '0;
            end
        end else begin
            presc_q    <= presc_d;
            ar_cnt_q   <= ar_cnt_d;
            act_q      <= act_d;
            timeout_q  <= timeout_d;
            err_id_q   <= err_id_d;
            err_kind_q <= err_kind_d;
            err_cnt_q  <= err_cnt_d;
            for (int i = 0; i < NumSlots; i++) begin
                slot_id_q[i]  <= slot_id_d[i];
                slot_cnt_q[i] <= slot_cnt_d[i];
            end
        end
    end

    assign busy_o     = |act_q;
    assign timeout_o  = timeout_q;
    assign err_id_o   = err_id_q;
    assign err_kind_o = err_kind_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_axi_rd_budget_tracker.sv
// Bench for axi_rd_budget_tracker: directed scenarios plus random traffic, every cycle compared
// against a slot-table reference model kept in plain integers.
module tb_axi_rd_budget_tracker;

    localparam int IW  = 6;
    localparam int NS  = 8;
    localparam int CW  = 10;
    localparam int DIV = 16;
    localparam int EW  = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst, enable, err_clear;
    logic [CW-1:0] cfg_ar, cfg_base, cfg_unit;
    logic          ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [IW-1:0] ar_id, r_id;
    logic [7:0]    ar_len;
    logic          ar_stall_o, busy_o, timeout_o;
    logic [IW-1:0] err_id_o;
    logic [1:0]    err_kind_o;
    logic [EW-1:0] err_cnt_o;

    int total = 0;
    int bad   = 0;

    bit m_act [NS];
    int m_id  [NS];
    int m_left[NS];
    int m_cyc, m_ar_left;
    bit m_to;
    int m_eid, m_ekind, m_ecnt;

    axi_rd_budget_tracker #(
        .IdWidth(IW), .NumSlots(NS), .CntWidth(CW), .PrescalerDiv(DIV), .ErrCntWidth(EW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .cfg_ar_budget_i(cfg_ar), .cfg_r_base_i(cfg_base), .cfg_r_unit_i(cfg_unit),
        .ar_valid_i(ar_valid), .ar_ready_i(ar_ready), .ar_id_i(ar_id), .ar_len_i(ar_len),
        .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last), .r_id_i(r_id),
        .ar_stall_o(ar_stall_o), .busy_o(busy_o), .timeout_o(timeout_o),
        .err_id_o(err_id_o), .err_kind_o(err_kind_o), .err_cnt_o(err_cnt_o),
        .err_clear_i(err_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        bit full = 1'b1;
        bit hit  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (!m_act[i]) full = 1'b0;
            else if (m_id[i] == int'(ar_id)) hit = 1'b1;
        end
        return enable && ar_valid && (full || hit);
    endfunction

    function automatic bit m_busy();
        bit b = 1'b0;
        for (int i = 0; i < NS; i++) b |= m_act[i];
        return b;
    endfunction

    // Errors are listed in priority order; only the first one in a cycle supplies id/kind.
    function automatic void m_step();
        bit tick, stall, hs, rhs, e;
        int eid, ek, fidx, rj, b;
        if (rst) begin
            for (int i = 0; i < NS; i++) m_act[i] = 1'b0;
            m_cyc = 0; m_ar_left = 0;
            m_to = 1'b0; m_eid = 0; m_ekind = 0; m_ecnt = 0;
            return;
        end
        tick  = (m_cyc % DIV) == DIV - 1;
        stall = m_stall();
        hs    = ar_valid && ar_ready;
        rhs   = r_valid && r_ready;
        e = 1'b0; eid = 0; ek = 0;
        fidx = -1; rj = -1;
        for (int i = 0; i < NS; i++) begin
            if (!m_act[i] && fidx < 0) fidx = i;
            if (m_act[i] && m_id[i] == int'(r_id)) rj = i;
        end
        if (enable) begin
            if (hs && stall) begin
                if (!e) begin eid = int'(ar_id); ek = 3; end
                e = 1'b1;
            end
            if (rhs && rj < 0) begin
                if (!e) begin eid = int'(r_id); ek = 2; end
                e = 1'b1;
            end
            if (!ar_valid || hs) m_ar_left = int'(cfg_ar);
            else if (tick) begin
                if (m_ar_left == 0) begin
                    if (!e) begin eid = int'(ar_id); ek = 0; end
                    e = 1'b1;
                    m_ar_left = int'(cfg_ar);
                end else m_ar_left--;
            end
            for (int i = 0; i < NS; i++) begin
                if (m_act[i]) begin
                    if (rhs && r_last && i == rj) m_act[i] = 1'b0;
                    else if (tick) begin
                        if (m_left[i] == 0) begin
                            if (!e) begin eid = m_id[i]; ek = 1; end
                            e = 1'b1;
                            m_act[i] = 1'b0;
                        end else m_left[i]--;
                    end
                end
            end
            if (hs && !stall) begin
                b = int'(cfg_base) + (int'(ar_len) + 1) * int'(cfg_unit);
                m_act[fidx]  = 1'b1;
                m_id[fidx]   = int'(ar_id);
                m_left[fidx] = (b > CNT_MAX) ? CNT_MAX : b;
            end
        end else begin
            m_ar_left = int'(cfg_ar);
            for (int i = 0; i < NS; i++) m_act[i] = 1'b0;
        end
        if (err_clear) begin
            m_to = e; m_eid = e ? eid : 0; m_ekind = e ? ek : 0; m_ecnt = e ? 1 : 0;
        end else if (e) begin
            if (m_ecnt < ERR_MAX) m_ecnt++;
            if (!m_to) begin m_to = 1'b1; m_eid = eid; m_ekind = ek; end
        end
        m_cyc++;
    endfunction

    task automatic cyc();
        @(negedge clk);
        chk("ar_stall", ar_stall_o, m_stall());
        m_step();
        @(posedge clk);
        #1;
        chk("busy", busy_o, m_busy());
        chk("timeout", timeout_o, m_to);
        chk("err_id", err_id_o, m_eid);
        chk("err_kind", err_kind_o, m_ekind);
        chk("err_cnt", err_cnt_o, m_ecnt);
    endtask

    task automatic clr_in();
        ar_valid = 0; ar_ready = 0; ar_id = '0; ar_len = '0;
        r_valid = 0; r_ready = 0; r_last = 0; r_id = '0;
        err_clear = 0;
    endtask

    task automatic do_reset();
        clr_in(); rst = 1; cyc(); rst = 0; cyc();
    endtask

    task automatic send_ar(input int id, input int len);
        clr_in(); ar_valid = 1; ar_ready = 1; ar_id = IW'(id); ar_len = 8'(len); cyc(); clr_in();
    endtask

    task automatic send_r(input int id, input bit last);
        clr_in(); r_valid = 1; r_ready = 1; r_id = IW'(id); r_last = last; cyc(); clr_in();
    endtask

    task automatic idle(input int n);
        clr_in();
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wait_to(input string tag, input int limit);
        int k = 0;
        while (!timeout_o && k < limit) begin cyc(); k++; end
        chk(tag, timeout_o, 1);
    endtask

    initial begin
        int q[$];
        clr_in(); rst = 1; enable = 1;
        cfg_ar = CW'(100); cfg_base = CW'(1); cfg_unit = CW'(1);
        do_reset();
        chk("rst_busy", busy_o, 0);
        chk("rst_to", timeout_o, 0);
        chk("rst_cnt", err_cnt_o, 0);

        // basic read
        send_ar(5, 3);
        chk("basic_busy1", busy_o, 1);
        idle(3);
        for (int b = 0; b < 4; b++) send_r(5, b == 3);
        chk("basic_busy0", busy_o, 0);
        chk("basic_cnt", err_cnt_o, 0);
        chk("basic_to", timeout_o, 0);

        // R timeout
        do_reset();
        send_ar(5, 0);
        wait_to("rto_wait", 100);
        chk("rto_kind", err_kind_o, 1);
        chk("rto_id", err_id_o, 5);
        chk("rto_busy", busy_o, 0);

        // AR stall timeout
        cfg_ar = CW'(2);
        do_reset();
        ar_valid = 1; ar_ready = 0; ar_id = IW'(9);
        wait_to("arto_wait", 100);
        chk("arto_kind", err_kind_o, 0);
        chk("arto_id", err_id_o, 9);
        chk("arto_cnt1", err_cnt_o, 1);
        for (int k = 0; k < 47; k++) cyc();
        chk("arto_cnt_hold", err_cnt_o, 1);
        cyc();
        chk("arto_cnt2", err_cnt_o, 2);

        // capacity / duplicate / overflow
        cfg_ar = CW'(1023); cfg_base = CW'(500); cfg_unit = CW'(0);
        do_reset();
        for (int i = 0; i < NS; i++) send_ar(i, 0);
        ar_valid = 1; ar_id = IW'(8); #1;
        chk("cap_stall8", ar_stall_o, 1);
        cyc();
        ar_id = IW'(3); #1;
        chk("cap_stall3", ar_stall_o, 1);
        cyc();
        send_ar(8, 0);
        chk("ovf_kind", err_kind_o, 3);
        chk("ovf_id", err_id_o, 8);
        send_r(0, 1);
        ar_valid = 1; ar_id = IW'(8); #1;
        chk("ovf_noalloc", ar_stall_o, 0);
        cyc(); clr_in();

        // unexpected R, then later R timeout only counts
        cfg_base = CW'(1); cfg_unit = CW'(1);
        do_reset();
        send_r(12, 1);
        chk("unx_kind", err_kind_o, 2);
        chk("unx_id", err_id_o, 12);
        send_ar(5, 0);
        idle(70);
        chk("unx_cnt2", err_cnt_o, 2);
        chk("unx_keep_kind", err_kind_o, 2);
        chk("unx_keep_id", err_id_o, 12);

        // clear, then reset with active slots
        err_clear = 1; cyc(); err_clear = 0;
        chk("clr_to", timeout_o, 0);
        chk("clr_id", err_id_o, 0);
        chk("clr_kind", err_kind_o, 0);
        chk("clr_cnt", err_cnt_o, 0);
        cfg_base = CW'(500);
        for (int i = 1; i <= 3; i++) send_ar(i, 0);
        chk("rst3_busy1", busy_o, 1);
        rst = 1; cyc(); rst = 0;
        chk("rst3_busy0", busy_o, 0);
        idle(40);
        chk("rst3_noto", timeout_o, 0);

        // error counter saturation
        for (int k = 0; k < ERR_MAX + 20; k++) begin
            clr_in(); r_valid = 1; r_ready = 1; r_last = 1; r_id = IW'(40); cyc();
        end
        chk("cnt_sat", err_cnt_o, ERR_MAX);
        clr_in(); err_clear = 1; cyc(); clr_in();

        // saturated R budget
        cfg_base = CW'(1023); cfg_unit = CW'(1023);
        do_reset();
        send_ar(4, 255);
        wait_to("sat_wait", (CNT_MAX + 3) * DIV);
        chk("sat_kind", err_kind_o, 1);
        chk("sat_id", err_id_o, 4);

        // random traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(99, 0) < 3) begin
                cfg_ar   = CW'($urandom_range(6, 0));
                cfg_base = CW'($urandom_range(4, 0));
                cfg_unit = CW'($urandom_range(2, 0));
            end
            rst       = ($urandom_range(999, 0) < 3);
            enable    = ($urandom_range(99, 0) >= 3);
            err_clear = ($urandom_range(99, 0) < 2);
            ar_valid  = ($urandom_range(99, 0) < 40);
            ar_ready  = ($urandom_range(1, 0) == 1);
            ar_id     = IW'($urandom_range(9, 0));
            ar_len    = 8'($urandom_range(3, 0));
            r_valid   = ($urandom_range(99, 0) < 40);
            r_ready   = ($urandom_range(99, 0) < 70);
            r_last    = ($urandom_range(1, 0) == 1);
            q.delete();
            for (int i = 0; i < NS; i++) if (m_act[i]) q.push_back(m_id[i]);
            if (q.size() > 0 && $urandom_range(99, 0) < 70)
                r_id = IW'(q[$urandom_range(q.size() - 1, 0)]);
            else
                r_id = IW'($urandom_range(15, 0));
            cyc();
        end
        rst = 0; enable = 1; clr_in();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
